// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and FSM state encodings for uart_core.
//               The PARITY states exist only when UART_PARITY_EN is defined.
// Revision    : 1.0 - initial parametrised full-duplex release
// ============================================================================
package uart_pkg;

  // Smallest usable baud divisor; smaller requests are clamped up to it.
  localparam int c_MIN_DIV    = 4;
  // Number of flops on the asynchronous uart_rx input.
  localparam int c_SYNC_DEPTH = 2;
  // Bit-index counter width; covers up to 8 data bits or 2 stop bits.
  localparam int c_BIT_IDX_W  = 4;

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } txState_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rxState_t;
`else
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_STOP   = 3'd4
  } txState_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rxState_t;
`endif

endpackage
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : First-word-fall-through receive FIFO. popData shows the head
//               entry whenever the FIFO is non-empty (zero when empty).
//               A push into a full FIFO succeeds if a pop happens in the
//               same cycle.
// Revision    : 1.0 - initial release
// Ports       : clk, rst_n        clock, async active-low reset
//               push, pushData    write request and data
//               pop               read request (ignored when empty)
//               popData           head of FIFO
//               full, empty       status flags
//               level             occupancy, 0..RX_DEPTH
// ============================================================================
module uart_rx_fifo #(
  parameter int WIDTH    = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           pushData,
  input  logic                       pop,
  output logic [WIDTH-1:0]           popData,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(RX_DEPTH):0]  level
);

  localparam int c_AW = $clog2(RX_DEPTH);
  localparam logic [c_AW:0]   c_LVL_ONE  = (c_AW+1)'(1);
  localparam logic [c_AW:0]   c_LVL_FULL = (c_AW+1)'(RX_DEPTH);
  localparam logic [c_AW-1:0] c_PTR_ONE  = c_AW'(1);

  logic [WIDTH-1:0] r_mem [RX_DEPTH];
  logic [c_AW-1:0]  r_wrPtr;
  logic [c_AW-1:0]  r_rdPtr;
  logic [c_AW:0]    r_level;
  logic             w_doPush;
  logic             w_doPop;

  assign empty    = (r_level == '0);
  assign full     = (r_level == c_LVL_FULL);
  assign w_doPop  = pop & ~empty;
  // A pop in the same cycle frees the slot being written.
  assign w_doPush = push & (~full | w_doPop);
  assign popData  = empty ? '0 : r_mem[r_rdPtr];
  assign level    = r_level;

  // Pointers are c_AW bits wide, so they wrap modulo RX_DEPTH on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_level <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + c_PTR_ONE;
      if (w_doPop)  r_rdPtr <= r_rdPtr + c_PTR_ONE;
      case ({w_doPush, w_doPop})
        2'b10:   r_level <= r_level + c_LVL_ONE;
        2'b01:   r_level <= r_level - c_LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once pushed.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= pushData;
  end

endmodule
`default_nettype wire

// File: rtl/uart_core.sv
`default_nettype none
// ============================================================================
// Module      : uart_core
// Description : Full-duplex UART with runtime baud divisor, valid/ready TX
//               and RX handshakes, and a buffered RX path with framing and
//               overrun detection. Optional parity via macro UART_PARITY_EN
//               (adds input parity_odd and output pulse parity_err).
// Revision    : 1.0 - initial parametrised release
// Ports       : clk, rst_n           clock, async active-low reset
//               baud_div             clk cycles per bit (<4 behaves as 4)
//               tx_data/valid/ready  transmit handshake
//               uart_tx, uart_rx     serial pins (idle high)
//               rx_data/valid/ready  FWFT receive FIFO head and handshake
//               frame_err, overrun   1-cycle error pulses
//               rx_level             RX FIFO occupancy
// ============================================================================
module uart_core
  import uart_pkg::*;
#(
  parameter int DIV_W     = 16,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int RX_DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DIV_W-1:0]           baud_div,
  input  logic [DATA_BITS-1:0]       tx_data,
  input  logic                       tx_valid,
  output logic                       tx_ready,
  output logic                       uart_tx,
  input  logic                       uart_rx,
  output logic [DATA_BITS-1:0]       rx_data,
  output logic                       rx_valid,
  input  logic                       rx_ready,
  output logic                       frame_err,
  output logic                       overrun,
`ifdef UART_PARITY_EN
  input  logic                       parity_odd,
  output logic                       parity_err,
`endif
  output logic [$clog2(RX_DEPTH):0]  rx_level
);

  localparam logic [c_BIT_IDX_W-1:0] c_DATA_LAST = c_BIT_IDX_W'(DATA_BITS - 1);
  localparam logic [c_BIT_IDX_W-1:0] c_STOP_LAST = c_BIT_IDX_W'(STOP_BITS - 1);
  localparam logic [DIV_W-1:0]       c_DIV_ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0]       c_DIV_MIN   = DIV_W'(c_MIN_DIV);

  logic [DIV_W-1:0] w_divClamped;
  assign w_divClamped = (baud_div < c_DIV_MIN) ? c_DIV_MIN : baud_div;

  // ---------------------------------------------------------------- TX ----
  txState_t                 r_txState, w_txStateNext;
  logic [DIV_W-1:0]         r_txCnt, w_txCntNext;
  logic [DIV_W-1:0]         r_txDiv, w_txDivNext;
  logic [c_BIT_IDX_W-1:0]   r_txBit, w_txBitNext;
  logic [DATA_BITS-1:0]     r_txShift, w_txShiftNext;
  logic                     r_txLine, w_txLineNext;
  logic                     w_txBitEnd;
`ifdef UART_PARITY_EN
  logic                     r_txPar, w_txParNext;
`endif

  assign w_txBitEnd = (r_txCnt == r_txDiv - c_DIV_ONE);
  assign tx_ready   = (r_txState == TX_IDLE);
  assign uart_tx    = r_txLine;

  always_comb begin
    w_txStateNext = r_txState;
    w_txCntNext   = r_txCnt;
    w_txDivNext   = r_txDiv;
    w_txBitNext   = r_txBit;
    w_txShiftNext = r_txShift;
`ifdef UART_PARITY_EN
    w_txParNext   = r_txPar;
`endif
    case (r_txState)
      TX_IDLE: begin
        if (tx_valid) begin
          w_txStateNext = TX_START;
          w_txCntNext   = '0;
          w_txDivNext   = w_divClamped;
          w_txShiftNext = tx_data;
`ifdef UART_PARITY_EN
          w_txParNext   = (^tx_data) ^ parity_odd;
`endif
        end
      end
      TX_START: begin
        if (w_txBitEnd) begin
          w_txStateNext = TX_DATA;
          w_txCntNext   = '0;
          w_txBitNext   = '0;
        end else begin
          w_txCntNext = r_txCnt + c_DIV_ONE;
        end
      end
      TX_DATA: begin
        if (w_txBitEnd) begin
          w_txCntNext   = '0;
          w_txShiftNext = r_txShift >> 1;
          if (r_txBit == c_DATA_LAST) begin
            w_txBitNext   = '0;
`ifdef UART_PARITY_EN
            w_txStateNext = TX_PARITY;
`else
            w_txStateNext = TX_STOP;
`endif
          end else begin
            w_txBitNext = r_txBit + 1'b1;
          end
        end else begin
          w_txCntNext = r_txCnt + c_DIV_ONE;
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        if (w_txBitEnd) begin
          w_txStateNext = TX_STOP;
          w_txCntNext   = '0;
          w_txBitNext   = '0;
        end else begin
          w_txCntNext = r_txCnt + c_DIV_ONE;
        end
      end
`endif
      TX_STOP: begin
        if (w_txBitEnd) begin
          w_txCntNext = '0;
          if (r_txBit == c_STOP_LAST) begin
            w_txStateNext = TX_IDLE;
            w_txBitNext   = '0;
          end else begin
            w_txBitNext = r_txBit + 1'b1;
          end
        end else begin
          w_txCntNext = r_txCnt + c_DIV_ONE;
        end
      end
      default: w_txStateNext = TX_IDLE;
    endcase

    // Line level is decoded from the next state so uart_tx is a clean flop.
    case (w_txStateNext)
      TX_START:  w_txLineNext = 1'b0;
      TX_DATA:   w_txLineNext = w_txShiftNext[0];
`ifdef UART_PARITY_EN
      TX_PARITY: w_txLineNext = w_txParNext;
`endif
      default:   w_txLineNext = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_txState <= TX_IDLE;
      r_txCnt   <= '0;
      r_txDiv   <= c_DIV_MIN;
      r_txBit   <= '0;
      r_txShift <= '0;
      r_txLine  <= 1'b1;
`ifdef UART_PARITY_EN
      r_txPar   <= 1'b0;
`endif
    end else begin
      r_txState <= w_txStateNext;
      r_txCnt   <= w_txCntNext;
      r_txDiv   <= w_txDivNext;
      r_txBit   <= w_txBitNext;
      r_txShift <= w_txShiftNext;
      r_txLine  <= w_txLineNext;
`ifdef UART_PARITY_EN
      r_txPar   <= w_txParNext;
`endif
    end
  end

  // ---------------------------------------------------------------- RX ----
  logic [c_SYNC_DEPTH-1:0]  r_rxSync;
  logic                     w_rxIn;
  rxState_t                 r_rxState, w_rxStateNext;
  logic [DIV_W-1:0]         r_rxCnt, w_rxCntNext;
  logic [DIV_W-1:0]         r_rxDiv, w_rxDivNext;
  logic [c_BIT_IDX_W-1:0]   r_rxBit, w_rxBitNext;
  logic [DATA_BITS-1:0]     r_rxShift, w_rxShiftNext;
  logic                     w_rxMid, w_rxBitEnd;
  logic                     w_rxPush, w_rxPop;
  logic                     w_fifoFull, w_fifoEmpty;
  logic                     r_frameErr, w_frameErrNext;
  logic                     r_overrun, w_overrunNext;
`ifdef UART_PARITY_EN
  logic                     r_rxParBad, w_rxParBadNext;
  logic                     r_parityErr, w_parityErrNext;
  assign parity_err = r_parityErr;
`endif

  assign w_rxIn     = r_rxSync[c_SYNC_DEPTH-1];
  assign w_rxMid    = (r_rxCnt == (r_rxDiv >> 1));
  assign w_rxBitEnd = (r_rxCnt == r_rxDiv - c_DIV_ONE);
  assign rx_valid   = ~w_fifoEmpty;
  assign w_rxPop    = rx_valid & rx_ready;
  assign frame_err  = r_frameErr;
  assign overrun    = r_overrun;

  always_comb begin
    w_rxStateNext  = r_rxState;
    w_rxCntNext    = r_rxCnt;
    w_rxDivNext    = r_rxDiv;
    w_rxBitNext    = r_rxBit;
    w_rxShiftNext  = r_rxShift;
    w_rxPush       = 1'b0;
    w_frameErrNext = 1'b0;
    w_overrunNext  = 1'b0;
`ifdef UART_PARITY_EN
    w_rxParBadNext  = r_rxParBad;
    w_parityErrNext = 1'b0;
`endif
    case (r_rxState)
      RX_IDLE: begin
        if (!w_rxIn) begin
          w_rxStateNext = RX_START;
          w_rxCntNext   = '0;
          w_rxDivNext   = w_divClamped;
        end
      end
      RX_START: begin
        // Resample half a bit in; a high line here was only a glitch.
        if (w_rxMid) begin
          w_rxCntNext = '0;
          w_rxBitNext = '0;
          w_rxStateNext = w_rxIn ? RX_IDLE : RX_DATA;
        end else begin
          w_rxCntNext = r_rxCnt + c_DIV_ONE;
        end
      end
      RX_DATA: begin
        // Counter restarted at the start-bit midpoint, so a full bit
        // period later lands mid-bit.
        if (w_rxBitEnd) begin
          w_rxCntNext   = '0;
          w_rxShiftNext = {w_rxIn, r_rxShift[DATA_BITS-1:1]};
          if (r_rxBit == c_DATA_LAST) begin
`ifdef UART_PARITY_EN
            w_rxStateNext = RX_PARITY;
`else
            w_rxStateNext = RX_STOP;
`endif
          end else begin
            w_rxBitNext = r_rxBit + 1'b1;
          end
        end else begin
          w_rxCntNext = r_rxCnt + c_DIV_ONE;
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: begin
        if (w_rxBitEnd) begin
          w_rxCntNext    = '0;
          w_rxParBadNext = (w_rxIn != ((^r_rxShift) ^ parity_odd));
          w_rxStateNext  = RX_STOP;
        end else begin
          w_rxCntNext = r_rxCnt + c_DIV_ONE;
        end
      end
`endif
      RX_STOP: begin
        if (w_rxBitEnd) begin
          w_rxCntNext = '0;
          if (w_rxIn) begin
            w_rxStateNext = RX_IDLE;
`ifdef UART_PARITY_EN
            if (r_rxParBad) begin
              w_parityErrNext = 1'b1;
            end else
`endif
            if (w_fifoFull && !w_rxPop) begin
              w_overrunNext = 1'b1;
            end else begin
              w_rxPush = 1'b1;
            end
          end else begin
            // Framing error wins over any parity mismatch.
            w_frameErrNext = 1'b1;
            w_rxStateNext  = RX_WAIT_HIGH;
          end
        end else begin
          w_rxCntNext = r_rxCnt + c_DIV_ONE;
        end
      end
      RX_WAIT_HIGH: begin
        // Ride out a break so a held-low line does not look like a start.
        if (w_rxIn) w_rxStateNext = RX_IDLE;
      end
      default: w_rxStateNext = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rxSync   <= '1;
      r_rxState  <= RX_IDLE;
      r_rxCnt    <= '0;
      r_rxDiv    <= c_DIV_MIN;
      r_rxBit    <= '0;
      r_rxShift  <= '0;
      r_frameErr <= 1'b0;
      r_overrun  <= 1'b0;
`ifdef UART_PARITY_EN
      r_rxParBad  <= 1'b0;
      r_parityErr <= 1'b0;
`endif
    end else begin
      r_rxSync   <= {r_rxSync[c_SYNC_DEPTH-2:0], uart_rx};
      r_rxState  <= w_rxStateNext;
      r_rxCnt    <= w_rxCntNext;
      r_rxDiv    <= w_rxDivNext;
      r_rxBit    <= w_rxBitNext;
      r_rxShift  <= w_rxShiftNext;
      r_frameErr <= w_frameErrNext;
      r_overrun  <= w_overrunNext;
`ifdef UART_PARITY_EN
      r_rxParBad  <= w_rxParBadNext;
      r_parityErr <= w_parityErrNext;
`endif
    end
  end

  uart_rx_fifo #(
    .WIDTH    (DATA_BITS),
    .RX_DEPTH (RX_DEPTH)
  ) u_rxFifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (w_rxPush),
    .pushData (r_rxShift),
    .pop      (w_rxPop),
    .popData  (rx_data),
    .full     (w_fifoFull),
    .empty    (w_fifoEmpty),
    .level    (rx_level)
  );

endmodule
`default_nettype wire

// File: tb/tb_uart_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_core
// Description : Self-checking bench for uart_core (default build, parity
//               macro UART_PARITY_EN undefined). Expected bytes are queued
//               at stimulus time and a monitor compares every RX beat.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_core;

  localparam int DIV_W     = 16;
  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;
  localparam int RX_DEPTH  = 8;
  localparam int LVL_W     = $clog2(RX_DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [DIV_W-1:0]     baud_div = 16'd16;
  logic [DATA_BITS-1:0] tx_data = '0;
  logic                 tx_valid = 1'b0;
  logic                 tx_ready;
  logic                 uart_tx;
  logic                 uart_rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready = 1'b1;
  logic                 frame_err;
  logic                 overrun;
  logic [LVL_W-1:0]     rx_level;

  logic loopback = 1'b0;
  logic rxDrive  = 1'b1;
  assign uart_rx = loopback ? uart_tx : rxDrive;

  always #5 clk = ~clk;

  uart_core #(
    .DIV_W(DIV_W), .DATA_BITS(DATA_BITS), .STOP_BITS(STOP_BITS), .RX_DEPTH(RX_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .uart_tx(uart_tx),
    .uart_rx(uart_rx), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun), .rx_level(rx_level)
  );

  int errors = 0;
  int checks = 0;
  logic [8:0] expQ[$];
  int frameErrPulses = 0;
  int overrunPulses  = 0;
  int rxBeats        = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: line level during cycle k (1-based) after a frame is accepted.
  function automatic logic expLine(input logic [7:0] b, input int d, input int k);
    int pos;
    pos = (k - 1) / d;
    if (pos == 0) return 1'b0;
    if (pos <= DATA_BITS) return b[pos-1];
    return 1'b1;
  endfunction

  // Scoreboard monitor: every RX beat is compared against the queue head.
  initial begin
    logic [8:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (frame_err) frameErrPulses++;
        if (overrun)   overrunPulses++;
        if (rx_valid && rx_ready) begin
          rxBeats++;
          exp = (expQ.size() > 0) ? expQ.pop_front() : 9'h100;
          check("rx_data", {1'b0, rx_data}, exp);
        end
      end
    end
  end

  task automatic acceptTx(input logic [7:0] b, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (tx_ready) begin
        tx_data  = b;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        ok = 1'b1;
        return;
      end
    end
    check("tx_ready_timeout", tx_ready, 1);
  endtask

  task automatic sendLoop(input logic [7:0] b);
    bit ok;
    acceptTx(b, ok);
    if (ok) expQ.push_back({1'b0, b});
  endtask

  task automatic txFrameCheck(input logic [7:0] b, input int div);
    int d, n, bad;
    bit ok;
    d = (div < 4) ? 4 : div;
    n = d * (1 + DATA_BITS + STOP_BITS);
    bad = 0;
    baud_div = DIV_W'(div);
    acceptTx(b, ok);
    if (!ok) return;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (uart_tx !== expLine(b, d, k)) bad++;
      if (k == 1) check("tx_ready_busy", tx_ready, 0);
      if (k == n) check("tx_ready_last_stop", tx_ready, 0);
      // A request while busy must be ignored.
      if (k == n / 2) begin tx_data = ~b; tx_valid = 1'b1; end
      if (k == n / 2 + 1) tx_valid = 1'b0;
    end
    check("tx_frame_bad_cycles", bad, 0);
    @(negedge clk);
    check("tx_ready_return", tx_ready, 1);
    @(negedge clk);
    check("tx_idle_line", uart_tx, 1);
  endtask

  task automatic driveFrame(input logic [7:0] b, input int d, input logic stopVal);
    @(negedge clk);
    rxDrive = 1'b0;
    repeat (d) @(negedge clk);
    for (int i = 0; i < DATA_BITS; i++) begin
      rxDrive = b[i];
      repeat (d) @(negedge clk);
    end
    rxDrive = stopVal;
    repeat (d) @(negedge clk);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 20000 && expQ.size() > 0; i++) @(negedge clk);
    check("rx_drain_remaining", expQ.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0, ov0, beats0;
    bit ok;
    logic [7:0] b;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_rx_level", rx_level, 0);
    rst_n = 1'b1;

    // TX waveform: the reference frame, a clamped divisor, then random ones
    txFrameCheck(8'hA5, 16);
    txFrameCheck(8'h3B, 2);
    for (int i = 0; i < 4; i++) txFrameCheck(8'($urandom), $urandom_range(0, 12));

    // Loopback: fixed back-to-back bytes, then random bursts at random divisors
    loopback = 1'b1;
    baud_div = 16'd16;
    sendLoop(8'h00);
    sendLoop(8'hFF);
    sendLoop(8'h5A);
    waitDrain();
    for (int r = 0; r < 3; r++) begin
      baud_div = DIV_W'($urandom_range(0, 24));
      for (int i = 0; i < 4; i++) sendLoop(8'($urandom));
      waitDrain();
    end
    repeat (40) @(negedge clk);
    check("loop_frame_err", frameErrPulses, 0);
    check("loop_overrun", overrunPulses, 0);
    loopback = 1'b0;

    // Glitch shorter than half a bit: no byte, no error
    baud_div = 16'd16;
    fe0 = frameErrPulses; beats0 = rxBeats;
    @(negedge clk) rxDrive = 1'b0;
    repeat (5) @(negedge clk);
    rxDrive = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_rx_level", rx_level, 0);
    check("glitch_frame_err", frameErrPulses, fe0);
    check("glitch_beats", rxBeats, beats0);

    // Framing error followed by a break, then a good frame
    driveFrame(8'h3C, 16, 1'b0);
    repeat (100) @(negedge clk);
    rxDrive = 1'b1;
    repeat (20) @(negedge clk);
    check("ferr_pulses", frameErrPulses, fe0 + 1);
    check("ferr_no_push", rxBeats, beats0);
    check("ferr_rx_level", rx_level, 0);
    expQ.push_back(9'h011);
    driveFrame(8'h11, 16, 1'b1);
    waitDrain();
    check("ferr_single_pulse", frameErrPulses, fe0 + 1);

    // Overrun: nine bytes into an eight-entry FIFO with no reader
    @(posedge clk); #1 rx_ready = 1'b0;
    baud_div = 16'd8;
    ov0 = overrunPulses;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom);
      if (i < RX_DEPTH) expQ.push_back({1'b0, b});
      driveFrame(b, 8, 1'b1);
    end
    repeat (4) @(negedge clk);
    check("ovr_rx_level", rx_level, RX_DEPTH);
    check("ovr_pulses", overrunPulses, ov0 + 1);
    check("ovr_rx_valid", rx_valid, 1);
    check("ovr_head_fwft", {1'b0, rx_data}, expQ[0]);
    @(posedge clk); #1 rx_ready = 1'b1;
    waitDrain();
    @(negedge clk);
    check("ovr_drained_level", rx_level, 0);

    // Reset in the middle of a TX data bit
    baud_div = 16'd16;
    acceptTx(8'h00, ok);
    repeat (40) @(posedge clk);
    #2;
    check("pre_rst_tx_line", uart_tx, 0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_uart_tx", uart_tx, 1);
    check("mid_rst_tx_ready", tx_ready, 1);
    @(negedge clk) rst_n = 1'b1;
    txFrameCheck(8'hC3, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_core.md
Name: uart_core

Overview:
- Parametrised full-duplex UART: the next generation of the team's fixed-baud, hard-coded-message UART.
- Adds a runtime baud divisor, configurable data/stop bits, and valid/ready handshakes on TX and RX.
- Adds a buffered RX path with framing and overrun detection.
- Sits between the RV32 core's memory-mapped UART registers and the board uart_rx/uart_tx pins.

Parameters:
- DIV_W, 16, width of the baud divisor input
- DATA_BITS, 8, data bits per frame (5..8)
- STOP_BITS, 1, stop bits sent by TX (1 or 2); RX always checks one
- RX_DEPTH, 8, RX FIFO entries (power of 2, >=2)

Ports:
- clk  in  1  system clock (27 MHz on board)
- rst_n  in  1  asynchronous active-low reset
- baud_div  in  DIV_W  clk cycles per bit (e.g. 234 for 115200 baud); values <4 behave as 4
- tx_data  in  DATA_BITS  byte to send
- tx_valid  in  1  TX request
- tx_ready  out  1  TX idle, accepts on valid&ready
- uart_tx  out  1  serial out, idle high
- uart_rx  in  1  serial in, asynchronous
- rx_data  out  DATA_BITS  head of RX FIFO
- rx_valid  out  1  FIFO non-empty
- rx_ready  in  1  pop on valid&ready
- frame_err  out  1  1-cycle pulse: stop bit sampled low
- overrun  out  1  1-cycle pulse: byte received while FIFO full
- rx_level  out  $clog2(RX_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async assert, sync-released use):
  - uart_tx=1, tx_ready=1, rx_valid=0, rx_data=0, frame_err=0, overrun=0, rx_level=0.
  - FIFO emptied; both FSMs to IDLE.
  - Reset mid-frame aborts immediately; uart_tx=1 in the same cycle.
- baud_div is latched per direction at frame start; changes mid-frame take effect on the next frame.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Accept when tx_valid&tx_ready: tx_ready=0 from the next cycle, and uart_tx=0 from the next cycle.
  - Each bit is held exactly baud_div cycles; data is sent LSB first.
  - STOP holds 1 for STOP_BITS*baud_div cycles.
  - tx_ready returns to 1 the cycle after the last stop cycle. Back-to-back frames have no extra idle gap.
  - tx_valid while tx_ready=0 is ignored; the data is not captured.
- RX synchroniser: two flops on uart_rx, reset to 1. All RX logic uses the synchronised value.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> WAIT_HIGH -> IDLE.
  - IDLE: a synchronised 0 enters START with counter=0.
  - START: at count baud_div/2 (integer) resample. If 1, false start: return to IDLE with no pulse.
  - DATA: sample every baud_div cycles (mid-bit), shift in LSB first, DATA_BITS samples.
  - STOP: sample at mid-bit.
    - If 1: push to FIFO, or if the FIFO is full (level==RX_DEPTH), drop the byte and pulse overrun.
    - If 0: pulse frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until the line is 1. This handles break conditions so there are no spurious starts. A valid stop skips WAIT_HIGH and goes directly to IDLE.
- FIFO: first-word-fall-through; rx_data is valid whenever rx_valid=1.
  - Simultaneous push and pop when full: the pop frees space and the push succeeds, with no overrun.
  - Simultaneous push and pop when empty: the pushed byte appears the next cycle.
  - rx_level updates the cycle after a push or pop.
  - Pointers wrap modulo RX_DEPTH.
- Latency: the byte is visible on rx_valid 1 cycle after the stop-bit sample cycle.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined: adds inputs parity_odd (1 bit) and an output pulse parity_err.
  - TX inserts a parity bit (even, or odd if parity_odd) after the data bits, for one bit period.
  - RX samples parity mid-bit. On mismatch it pulses parity_err and discards the byte. A simultaneous frame error takes precedence, and only frame_err pulses.
- Undefined: no PARITY state, no extra ports; frame = start + data + stop.

Decomposition:
- Shared package uart_pkg holds:
  - TX and RX state encodings as localparam/enum values.
  - The minimum-divisor constant (4).
  - The synchroniser depth constant (2).
- Natural sub-module: uart_rx_fifo, parametrised by width and RX_DEPTH, with push/pop/level.
- The TX and RX FSMs stay in uart_core.

Test Plan:
- baud_div=16, send 0xA5 -> uart_tx low for 16 cycles, bits 1,0,1,0,0,1,0,1 at 16 each, high 16; tx_ready=1 at cycle 161 after accept.
- Loop uart_tx to uart_rx, send 0x00, 0xFF, 0x5A back to back with rx_ready=1 -> three rx_valid beats with the same data, no errors.
- Drive a 5-cycle low glitch at baud_div=16 -> no rx_valid, no frame_err; RX returns to IDLE.
- Frame with stop bit 0 (0x3C), then line held low 100 cycles -> frame_err one pulse, no push, next valid frame 0x11 received correctly.
- RX_DEPTH=8, rx_ready=0, send 9 bytes -> rx_level=8, overrun pulse on 9th; then pop all -> the first 8 bytes in order.
- Assert rst_n=0 mid-TX data bit -> uart_tx=1 and tx_ready=1 immediately; the next request transmits a full frame.
